// File: rtl/spi_reg_bridge_pkg.sv
// Shared definitions for the SPI-to-control-register bridge.
// Contents: SPI FSM state encoding, reg0 bit positions, R/W opcode values
// and the reg0 reset value. No ports.
package spi_reg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_HOLD
  } state_t;

  // Bit positions inside control register 0
  localparam int SHUTTER = 0;
  localparam int MODE    = 1;
  localparam int RST_PIX = 2;
  localparam int APULSE  = 3;

  // First bit of every frame
  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  // Pixel reset is released out of reset; every other reg0 bit is clear
  localparam logic [3:0] REG0_RST = 4'b0100;

endpackage

// File: rtl/spi_reg_bridge_if.sv
// Bus bundle of the bridge: SPI slave pins plus the configuration stream.
//   spi_cs     frame select, active low (master -> bridge)
//   spi_sdi    serial data into the bridge
//   spi_sdo    serial data out of the bridge
//   cfg_data   FIFO head word (bridge -> column logic)
//   cfg_valid  FIFO not empty
//   cfg_ready  consumer accepts cfg_data
// Modport master is the SPI host / consumer side, slave is the bridge.
interface spi_reg_bridge_if #(
  parameter int DATA_W = 8
);
  logic              spi_cs;
  logic              spi_sdi;
  logic              spi_sdo;
  logic [DATA_W-1:0] cfg_data;
  logic              cfg_valid;
  logic              cfg_ready;

  modport master (
    output spi_cs, spi_sdi, cfg_ready,
    input  spi_sdo, cfg_data, cfg_valid
  );

  modport slave (
    input  spi_cs, spi_sdi, cfg_ready,
    output spi_sdo, cfg_data, cfg_valid
  );
endinterface

// File: rtl/spi_reg_bridge_cfg_fifo.sv
// Synchronous configuration FIFO with fill level and sticky overflow flag.
//   clk, rst_n  clock and asynchronous active-low reset
//   push/wdata  write request; dropped (and overflow set) when full unless
//               a pop happens on the same edge
//   pop         pop request; ignored while empty
//   clr_ovf     clears the overflow flag (a new overflow on the same edge wins)
//   rdata       head word, valid when valid is high (no fall-through)
//   level       number of stored words, 0..DEPTH
//   ovf         sticky overflow flag
module cfg_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  input  logic              clr_ovf,
  output logic [DATA_W-1:0] rdata,
  output logic              valid,
  output logic [LVL_W-1:0]  level,
  output logic              ovf
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_pop;
  logic              do_push;

  assign do_pop  = pop && (level != '0);
  assign do_push = push && ((level < LVL_W'(DEPTH)) || do_pop);

  // NOTE: storage is deliberately not reset; only words covered by level are
  // ever observed, so clearing the array would buy nothing.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side sees the pre-edge value regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      ovf    <= 1'b0;
    end else begin
      // Pointers are PTR_W wide, so the increment wraps modulo DEPTH
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      level <= level + 1'b1;
      else if (!do_push && do_pop) level <= level - 1'b1;
      if (push && !do_push) ovf <= 1'b1;
      else if (clr_ovf)     ovf <= 1'b0;
    end
  end

  assign rdata = mem[rd_ptr];
  assign valid = (level != '0);

endmodule

// File: rtl/spi_reg_bridge.sv
// SPI slave bridging to a control register bank, a read-only status bank
// and a configuration FIFO. Everything runs on the free-running spi_clk.
// Frame (MSB first): R/W bit (1 = write), ADDR_W address bits, DATA_W data.
// Address CFG_ADDR (all ones) writes into the FIFO and reads back
// {overflow, zeros, level}; reading it clears the overflow flag.
// Build option: define SPI_BURST_EN to keep streaming words after the first
// one (address auto-increments, CFG_ADDR stays put); otherwise the FSM
// parks in HOLD after one word until spi_cs rises.
// Ports:
//   spi_clk, rst_n  clock and asynchronous active-low reset
//   bus             spi_reg_bridge_if.slave: SPI pins + cfg stream
//   stat_in         status words, word i at address NUM_REGS+i
//   ctrl_regs       flat control bank, reg i at bits [i*DATA_W +: DATA_W]
//   shutter, mode, apulse_en  reg0 bits 0, 1, 3
//   rst_n_pixel     rst_n AND reg0 bit 2 (combinational)
module spi_reg_bridge
  import spi_reg_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 4,
  parameter int NUM_REGS   = 4,
  parameter int STAT_REGS  = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          spi_clk,
  input  logic                          rst_n,
  spi_reg_bridge_if.slave               bus,
  input  logic [STAT_REGS*DATA_W-1:0]   stat_in,
  output logic [NUM_REGS*DATA_W-1:0]    ctrl_regs,
  output logic                          shutter,
  output logic                          mode,
  output logic                          apulse_en,
  output logic                          rst_n_pixel
);

  localparam int LVL_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int CNT_MAX = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [ADDR_W-1:0] CFG_ADDR = '1;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              rw;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-2:0] data_sh;
  logic [DATA_W-1:0] sdo_sh;
  logic              sdo;

  logic              active;
  logic [ADDR_W-1:0] addr_next;
  logic [ADDR_W-1:0] addr_inc;
  logic [DATA_W-1:0] data_next;
  logic              addr_last;
  logic              data_last;
  logic              rd_load;
  logic [ADDR_W-1:0] rd_sel_addr;
  logic [DATA_W-1:0] rd_word;
  logic              wr_commit;
  logic              push;
  logic              clr_ovf;
  logic [LVL_W-1:0]  level;
  logic              ovf;

  assign active    = !bus.spi_cs;
  assign addr_next = {addr[ADDR_W-2:0], bus.spi_sdi};
  assign addr_inc  = (addr == CFG_ADDR) ? addr : addr + 1'b1;
  assign data_next = {data_sh, bus.spi_sdi};
  assign addr_last = ((state == ST_CMD) || (state == ST_ADDR)) &&
                     (cnt == CNT_W'(ADDR_W - 1));
  assign data_last = (state == ST_DATA) && (cnt == CNT_W'(DATA_W - 1));

`ifdef SPI_BURST_EN
  assign rd_load = active && (rw == OP_READ) && (addr_last || data_last);
`else
  assign rd_load = active && (rw == OP_READ) && addr_last;
`endif

  // At the end of the address phase the word comes from the address being
  // completed this edge; at a burst word boundary from the following one.
  assign rd_sel_addr = (state == ST_DATA) ? addr_inc : addr_next;

  assign wr_commit = active && data_last && (rw == OP_WRITE);
  assign push      = wr_commit && (addr == CFG_ADDR);
  assign clr_ovf   = rd_load && (rd_sel_addr == CFG_ADDR);

  // NOTE: rd_word gets a default before any conditional assignment, so
  // unmapped addresses read as zero and no latch is inferred.
  always_comb begin
    rd_word = '0;
    if (rd_sel_addr == CFG_ADDR) begin
      rd_word[LVL_W-1:0]  = level;
      rd_word[DATA_W-1]   = ovf;
    end
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_sel_addr == ADDR_W'(i)) rd_word = ctrl_regs[i*DATA_W +: DATA_W];
    end
    for (int i = 0; i < STAT_REGS; i++) begin
      if (rd_sel_addr == ADDR_W'(NUM_REGS + i)) rd_word = stat_in[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge spi_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      rw        <= OP_READ;
      addr      <= '0;
      data_sh   <= '0;
      sdo_sh    <= '0;
      sdo       <= 1'b0;
      ctrl_regs <= (NUM_REGS*DATA_W)'(REG0_RST);
    end else if (!active) begin
      // Deselect aborts whatever is in flight; partial words never commit
      state <= ST_IDLE;
      cnt   <= '0;
      sdo   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          state <= ST_CMD;
          rw    <= bus.spi_sdi;
          cnt   <= '0;
          sdo   <= 1'b0;
        end
        ST_CMD, ST_ADDR: begin
          addr  <= addr_next;
          state <= ST_ADDR;
          cnt   <= cnt + 1'b1;
          if (addr_last) begin
            state <= ST_DATA;
            cnt   <= '0;
            if (rd_load) begin
              sdo    <= rd_word[DATA_W-1];
              sdo_sh <= {rd_word[DATA_W-2:0], 1'b0};
            end else begin
              // Writes shift zeros so spi_sdo stays low
              sdo_sh <= '0;
            end
          end
        end
        ST_DATA: begin
          data_sh <= data_next[DATA_W-2:0];
          sdo     <= sdo_sh[DATA_W-1];
          sdo_sh  <= {sdo_sh[DATA_W-2:0], 1'b0};
          cnt     <= cnt + 1'b1;
          if (data_last) begin
            cnt <= '0;
            if (rw == OP_WRITE) begin
              for (int i = 0; i < NUM_REGS; i++) begin
                if (addr == ADDR_W'(i)) ctrl_regs[i*DATA_W +: DATA_W] <= data_next;
              end
            end
`ifdef SPI_BURST_EN
            addr <= addr_inc;
            if (rd_load) begin
              sdo    <= rd_word[DATA_W-1];
              sdo_sh <= {rd_word[DATA_W-2:0], 1'b0};
            end
`else
            state <= ST_HOLD;
            sdo   <= 1'b0;
`endif
          end
        end
        ST_HOLD: sdo <= 1'b0;
        default: state <= ST_IDLE;
      endcase
    end
  end

  cfg_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_cfg_fifo (
    .clk     (spi_clk),
    .rst_n   (rst_n),
    .push    (push),
    .wdata   (data_next),
    .pop     (bus.cfg_ready),
    .clr_ovf (clr_ovf),
    .rdata   (bus.cfg_data),
    .valid   (bus.cfg_valid),
    .level   (level),
    .ovf     (ovf)
  );

  assign bus.spi_sdo = sdo;
  assign shutter     = ctrl_regs[SHUTTER];
  assign mode        = ctrl_regs[MODE];
  assign apulse_en   = ctrl_regs[APULSE];
  assign rst_n_pixel = rst_n & ctrl_regs[RST_PIX];

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Self-checking bench for spi_reg_bridge: directed scenarios plus random
// frames, compared against a register/queue reference model.
module tb_spi_reg_bridge;
  import spi_reg_pkg::*;

  localparam int DATA_W     = 8;
  localparam int ADDR_W     = 4;
  localparam int NUM_REGS   = 4;
  localparam int STAT_REGS  = 4;
  localparam int FIFO_DEPTH = 8;
  localparam int CFG        = (1 << ADDR_W) - 1;

  logic spi_clk = 1'b0;
  logic rst_n   = 1'b0;
  logic [STAT_REGS*DATA_W-1:0] stat_in;
  logic [NUM_REGS*DATA_W-1:0]  ctrl_regs;
  logic shutter, mode, apulse_en, rst_n_pixel;

  spi_reg_bridge_if #(.DATA_W(DATA_W)) bus ();

  spi_reg_bridge #(
    .DATA_W     (DATA_W),
    .ADDR_W     (ADDR_W),
    .NUM_REGS   (NUM_REGS),
    .STAT_REGS  (STAT_REGS),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .spi_clk     (spi_clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .stat_in     (stat_in),
    .ctrl_regs   (ctrl_regs),
    .shutter     (shutter),
    .mode        (mode),
    .apulse_en   (apulse_en),
    .rst_n_pixel (rst_n_pixel)
  );

  always #5 spi_clk = ~spi_clk;

  int total = 0;
  int bad   = 0;

  // Reference model
  logic [DATA_W-1:0] m_regs [NUM_REGS];
  logic [DATA_W-1:0] m_fifo [$];
  logic              m_ovf;

  logic [DATA_W-1:0] tx_q  [$];
  logic [DATA_W-1:0] rx_q  [$];
  logic [DATA_W-1:0] exp_q [$];
  bit scramble    = 1'b0;
  bit pop_on_last = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < NUM_REGS; i++) m_regs[i] = '0;
    m_regs[0] = 8'h04;
    m_fifo.delete();
    m_ovf = 1'b0;
  endtask

  function automatic int next_addr(input int a);
    return (a == CFG) ? CFG : (a + 1) % (1 << ADDR_W);
  endfunction

  task automatic m_read(input int a, output logic [DATA_W-1:0] r);
    r = '0;
    if (a < NUM_REGS) r = m_regs[a];
    else if (a < NUM_REGS + STAT_REGS) r = stat_in[(a - NUM_REGS)*DATA_W +: DATA_W];
    else if (a == CFG) begin
      r = DATA_W'(m_fifo.size());
      r[DATA_W-1] = m_ovf;
      m_ovf = 1'b0;
    end
  endtask

  task automatic m_write(input int a, input logic [DATA_W-1:0] w);
    if (a < NUM_REGS) m_regs[a] = w;
    else if (a == CFG) begin
      if (m_fifo.size() < FIFO_DEPTH) m_fifo.push_back(w);
      else m_ovf = 1'b1;
    end
  endtask

  task automatic randomize_stat();
    for (int k = 0; k < STAT_REGS; k++) stat_in[k*DATA_W +: DATA_W] = DATA_W'($urandom);
  endtask

  task automatic check_outputs(input string tag);
    for (int i = 0; i < NUM_REGS; i++)
      check($sformatf("%s reg%0d", tag, i), 32'(ctrl_regs[i*DATA_W +: DATA_W]), 32'(m_regs[i]));
    check({tag, " shutter"},     32'(shutter),       32'(m_regs[0][SHUTTER]));
    check({tag, " mode"},        32'(mode),          32'(m_regs[0][MODE]));
    check({tag, " apulse_en"},   32'(apulse_en),     32'(m_regs[0][APULSE]));
    check({tag, " rst_n_pixel"}, 32'(rst_n_pixel),   32'(m_regs[0][RST_PIX]));
    check({tag, " cfg_valid"},   32'(bus.cfg_valid), 32'(m_fifo.size() != 0));
    if (m_fifo.size() != 0) check({tag, " cfg_data"}, 32'(bus.cfg_data), 32'(m_fifo[0]));
    check({tag, " idle sdo"},    32'(bus.spi_sdo),   32'd0);
  endtask

  // One SPI frame. cut >= 0 raises spi_cs after that many data bits.
  task automatic do_frame(input logic rw, input int a, input int nwords, input int cut);
    int nbits, ncomp, aa;
    logic [DATA_W-1:0] r, w, cur;
    nbits = (cut >= 0) ? cut : nwords * DATA_W;
    ncomp = nbits / DATA_W;
    exp_q.delete();
    rx_q.delete();
    while (tx_q.size() < nwords) tx_q.push_back(DATA_W'($urandom));
    if (rw == OP_READ) begin
      m_read(a, r);
      exp_q.push_back(r);
`ifdef SPI_BURST_EN
      aa = a;
      for (int k = 1; k <= ncomp; k++) begin
        aa = next_addr(aa);
        m_read(aa, r);
        exp_q.push_back(r);
      end
`else
      for (int k = 1; k < nwords; k++) exp_q.push_back('0);
`endif
    end
    @(negedge spi_clk);
    bus.spi_cs  = 1'b0;
    bus.spi_sdi = rw;
    @(posedge spi_clk);
    for (int i = ADDR_W - 1; i >= 0; i--) begin
      @(negedge spi_clk);
      bus.spi_sdi = a[i];
      @(posedge spi_clk);
    end
    cur = '0;
    for (int j = 0; j < nbits; j++) begin
      w = tx_q[j / DATA_W];
      @(negedge spi_clk);
      cur = {cur[DATA_W-2:0], bus.spi_sdo};
      bus.spi_sdi = w[DATA_W - 1 - (j % DATA_W)];
      if (scramble && j == 2) randomize_stat();
      if (pop_on_last && j == nbits - 1) bus.cfg_ready = 1'b1;
      @(posedge spi_clk);
      if (j % DATA_W == DATA_W - 1) rx_q.push_back(cur);
    end
    @(negedge spi_clk);
    bus.spi_cs    = 1'b1;
    bus.spi_sdi   = 1'b0;
    bus.cfg_ready = 1'b0;
    @(posedge spi_clk);
    if (pop_on_last) void'(m_fifo.pop_front());
    if (rw == OP_WRITE) begin
`ifdef SPI_BURST_EN
      aa = a;
      for (int k = 0; k < ncomp; k++) begin
        m_write(aa, tx_q[k]);
        aa = next_addr(aa);
      end
`else
      if (ncomp >= 1) m_write(a, tx_q[0]);
`endif
    end else begin
      for (int k = 0; k < rx_q.size(); k++)
        check($sformatf("read a=%0d w%0d", a, k), 32'(rx_q[k]), 32'(exp_q[k]));
    end
    tx_q.delete();
    @(negedge spi_clk);
    check_outputs($sformatf("after %s a=%0d", (rw == OP_WRITE) ? "wr" : "rd", a));
  endtask

  // Called at a negedge with cfg_ready low
  task automatic drain();
    logic [DATA_W-1:0] e;
    while (m_fifo.size() != 0) begin
      @(negedge spi_clk);
      e = m_fifo.pop_front();
      check("drain valid", 32'(bus.cfg_valid), 32'd1);
      check("drain data",  32'(bus.cfg_data),  32'(e));
      bus.cfg_ready = 1'b1;
    end
    @(negedge spi_clk);
    bus.cfg_ready = 1'b0;
    check("drain empty", 32'(bus.cfg_valid), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic rw;
    int a, cut;
    bus.spi_cs    = 1'b1;
    bus.spi_sdi   = 1'b0;
    bus.cfg_ready = 1'b0;
    randomize_stat();
    m_reset();

    // Reset state
    #1;
    check("in reset rst_n_pixel", 32'(rst_n_pixel), 32'd0);
    repeat (3) @(negedge spi_clk);
    rst_n = 1'b1;
    @(negedge spi_clk);
    check("reset reg0", 32'(ctrl_regs[DATA_W-1:0]), 32'h04);
    check_outputs("reset");

    // Control write then read-back
    tx_q.push_back(8'h0B);
    do_frame(OP_WRITE, 0, 1, -1);
    check("wr0 shutter", 32'(shutter), 32'd1);
    check("wr0 mode", 32'(mode), 32'd1);
    check("wr0 apulse_en", 32'(apulse_en), 32'd1);
    check("wr0 rst_n_pixel", 32'(rst_n_pixel), 32'd0);
    do_frame(OP_READ, 0, 1, -1);
    check("rd0 value", 32'(rx_q[0]), 32'h0B);

    // Status snapshot while stat_in changes mid data phase
    stat_in[2*DATA_W +: DATA_W] = 8'hA5;
    scramble = 1'b1;
    do_frame(OP_READ, NUM_REGS + 2, 1, -1);
    scramble = 1'b0;
    check("status snapshot", 32'(rx_q[0]), 32'hA5);

    // FIFO overflow
    for (int k = 0; k < FIFO_DEPTH + 1; k++) do_frame(OP_WRITE, CFG, 1, -1);
    do_frame(OP_READ, CFG, 1, -1);
    check("cfg level+ovf", 32'(rx_q[0]), 32'h88);
    do_frame(OP_READ, CFG, 1, -1);
    check("cfg ovf cleared", 32'(rx_q[0]), 32'h08);
    // Push into a full FIFO on the same edge as a pop: accepted, no overflow
    pop_on_last = 1'b1;
    do_frame(OP_WRITE, CFG, 1, -1);
    pop_on_last = 1'b0;
    do_frame(OP_READ, CFG, 1, -1);
    check("full push+pop", 32'(rx_q[0]), 32'h08);
    drain();

    // Aborted write, then a clean frame
    do_frame(OP_WRITE, 1, 1, 5);
    tx_q.push_back(8'h5C);
    do_frame(OP_WRITE, 1, 1, -1);
    do_frame(OP_READ, 1, 1, -1);
    check("after abort rd1", 32'(rx_q[0]), 32'h5C);

    // Burst write of three words from address 1
    tx_q.push_back(8'h11);
    tx_q.push_back(8'h22);
    tx_q.push_back(8'h33);
    do_frame(OP_WRITE, 1, 3, -1);
    do_frame(OP_READ, 1, 3, -1);

    // Random frames
    for (int n = 0; n < 60; n++) begin
      randomize_stat();
      rw  = 1'($urandom_range(0, 1));
      a   = $urandom_range(0, CFG);
      cut = ($urandom_range(0, 7) == 0) ? $urandom_range(0, DATA_W - 1) : -1;
      do_frame(rw, a, 1, cut);
      if ($urandom_range(0, 9) == 0) drain();
    end
    drain();

    // Reset in the middle of a read frame
    tx_q.push_back(8'hFF);
    do_frame(OP_WRITE, 0, 1, -1);
    do_frame(OP_WRITE, CFG, 1, -1);
    @(negedge spi_clk);
    bus.spi_cs  = 1'b0;
    bus.spi_sdi = OP_READ;
    repeat (ADDR_W + 3) @(posedge spi_clk);
    #2 rst_n = 1'b0;
    #1;
    check("midreset rst_n_pixel", 32'(rst_n_pixel), 32'd0);
    check("midreset sdo", 32'(bus.spi_sdo), 32'd0);
    check("midreset cfg_valid", 32'(bus.cfg_valid), 32'd0);
    check("midreset reg0", 32'(ctrl_regs[DATA_W-1:0]), 32'h04);
    bus.spi_cs = 1'b1;
    @(negedge spi_clk);
    rst_n = 1'b1;
    m_reset();
    @(negedge spi_clk);
    check_outputs("post reset");
    do_frame(OP_READ, 0, 1, -1);
    do_frame(OP_READ, CFG, 1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_reg_bridge.md
# spi_reg_bridge

Parametrised successor to the SPI-to-control-register bridge for the pixel-array periphery. It implements an SPI slave, a generic read/write control register bank, a snapshot read-only status bank and a configuration FIFO. The FIFO streams configuration words to the column logic over a valid/ready handshake. All logic runs on `spi_clk`, which is free-running. `spi_cs` frames transactions.

## Interface
- `DATA_W`, 8: register and configuration word width; must be ≥ 4.
- `ADDR_W`, 4: address field width; 2^ADDR_W must be ≥ NUM_REGS+STAT_REGS+1.
- `NUM_REGS`, 4: number of read/write control registers, at addresses 0..NUM_REGS-1.
- `STAT_REGS`, 4: number of read-only status words, at addresses NUM_REGS..NUM_REGS+STAT_REGS-1.
- `FIFO_DEPTH`, 8: configuration FIFO depth; must be a power of two and ≥ 2.
- `spi_clk` in 1: the single clock. All logic is rising-edge.
- `rst_n` in 1: asynchronous active-low reset.
- `spi_cs` in 1: active-low frame select.
- `spi_sdi` in 1: serial data in, sampled on the rising edge.
- `spi_sdo` out 1: serial data out, registered. Resets to 0.
- `stat_in` in STAT_REGS*DATA_W: status words. Word i sits at address NUM_REGS+i.
- `ctrl_regs` out NUM_REGS*DATA_W: flat control bank. Resets to 0, except the reg0 `rst_n_pixel` bit, which resets to 1.
- `shutter`, `mode`, `apulse_en` out 1 each: reg0 bits 0, 1 and 3. Reset to 0.
- `rst_n_pixel` out 1: `rst_n` AND reg0 bit 2. This is combinational.
- `cfg_data` out DATA_W: FIFO head word.
- `cfg_valid` out 1: FIFO not empty. Resets to 0.
- `cfg_ready` in 1: consumer accepts the word. A pop occurs when `cfg_valid` and `cfg_ready` are both high on an edge.

## Operation
- **Frame format (MSB first):** 1 R/W bit (1 = write), then ADDR_W address bits, then DATA_W data bits.
- **States:** IDLE → CMD → ADDR → DATA.
  - `spi_cs` low in IDLE moves the FSM to CMD on the same edge, capturing bit 0.
  - `spi_cs` high in any state forces IDLE, resets the bit counter and discards a partial word.
- **Write commit:** on the edge that samples the last data bit.
  - Control address: update the register.
  - `CFG_ADDR` (= 2^ADDR_W−1): push the word to the FIFO.
  - Status or unmapped address: ignore.
- **Read:** on the edge that samples the last address bit, load the read word into the output shift register.
  - Control address: register value.
  - Status address: `stat_in` word, snapshotted at that edge.
  - `CFG_ADDR`: {overflow flag, zero padding, FIFO level}, with level $clog2(FIFO_DEPTH)+1 bits wide. Reading clears the overflow flag.
  - Unmapped address: 0.
  - Data bits received during a read are ignored.
- **FIFO push/pop:**
  - A push is accepted when level < FIFO_DEPTH, or when a pop happens on the same edge.
  - Otherwise the word is dropped and the sticky overflow flag is set.
  - A pop on an empty FIFO is impossible, because `cfg_valid` is low.
  - Pointers wrap modulo FIFO_DEPTH.
- **End of frame:** after DATA completes, further bits are handled as defined under Configuration, until `spi_cs` goes high.
- **Reset mid-frame:**
  - Clears the FSM, registers, FIFO, flag and `spi_sdo` immediately.
  - `rst_n_pixel` drops combinationally.
  - Reg0 bit 2 returns to 1.

## Timing
- **Edge numbering:** edge 1 is the first rising edge with `spi_cs` low.
  - Edge 1: R/W bit.
  - Edges 2..1+ADDR_W: address bits.
  - Edges 2+ADDR_W..1+ADDR_W+DATA_W: data bits.
- **Write:** the register output is visible after edge 1+ADDR_W+DATA_W. `cfg_valid` rises after that same edge if the FIFO was empty.
- **Read:** the MSB appears on `spi_sdo` after edge 1+ADDR_W. One bit shifts per edge after that. The master samples bit k on edge 2+ADDR_W+k.
- **Idle output:** `spi_sdo` is 0 whenever the FSM is not in a read DATA phase.
- **FIFO latency:** one cycle from push to `cfg_valid`. There is no fall-through.

## Configuration
- **`SPI_BURST_EN` defined:** after each DATA word the FSM stays in DATA.
  - The address auto-increments, wrapping modulo 2^ADDR_W, and the next read word is loaded at the word boundary.
  - `CFG_ADDR` does not increment, so a burst streams words into the FIFO.
- **`SPI_BURST_EN` undefined:** after one DATA word the FSM enters a hold state. It ignores `spi_sdi`, drives `spi_sdo` = 0, and waits for `spi_cs` high.

## Structure
- **Package `spi_reg_pkg`:**
  - FSM state enum (IDLE, CMD, ADDR, DATA, HOLD).
  - Reg0 bit-index constants: SHUTTER = 0, MODE = 1, RST_PIX = 2, APULSE = 3.
  - R/W opcode constants.
  - Reg0 reset value 4'b0100.
- **Sub-module `cfg_fifo`:** synchronous FIFO with level output and overflow flag. The top level holds the SPI FSM and the register banks.

## Test plan
- **Reset:** after reset release, reg0 = 0x04, `rst_n_pixel` = 1, `cfg_valid` = 0, `spi_sdo` = 0.
- **Control write and read-back:** write 0x0B to addr 0, then read addr 0. Expect `shutter` = 1, `mode` = 1, `apulse_en` = 1, `rst_n_pixel` = 0, and `spi_sdo` shifting out 00001011.
- **Status snapshot:** set `stat_in` word 2 = 0xA5 and read addr 6. Change `stat_in` during the data phase. Expect 0xA5.
- **FIFO overflow and handshake:**
  - With `cfg_ready` = 0, push 9 words to addr 15. Read addr 15 → level 8 with the overflow flag set; a second read shows the flag cleared.
  - Assert `cfg_ready`. Expect the first 8 words in order, then `cfg_valid` = 0.
- **Aborted frame:** raise `spi_cs` after 5 data bits of a write. Expect the register unchanged and the next frame decoded correctly.
- **Burst (`SPI_BURST_EN`):** write 0x11, 0x22, 0x33 starting at addr 1. Expect regs 1..3 updated. Without the macro, only reg 1 changes.
